// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
//   Shared definitions for the fetch sequencer: opcode constants, the MOV
//   immediate sub-field value, the 3-bit fetch state encoding and a helper
//   that recognises the two-word instruction form.
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

  // Opcode field lives in the top nibble of the first instruction word.
  localparam logic [3:0] OPC_MOV = 4'h0;
  localparam logic [3:0] OPC_ADD = 4'h1;
  localparam logic [3:0] OPC_SUB = 4'h2;
  localparam logic [3:0] OPC_AND = 4'h3;
  localparam logic [3:0] OPC_OR  = 4'h4;
  localparam logic [3:0] OPC_JMP = 4'h5;
  localparam logic [3:0] OPC_BR  = 4'h6;

  // Low nibble of a MOV selecting the immediate form; the immediate itself
  // follows as a second word.
  localparam logic [3:0] MOV_IMM = 4'h8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH1 = 3'd1,
    ST_LOAD1  = 3'd2,
    ST_FETCH2 = 3'd3,
    ST_LOAD2  = 3'd4,
    ST_VALID  = 3'd5,
    ST_HALT   = 3'd6
  } fetch_state_t;

  // True when the first word announces a trailing immediate word.
  function automatic logic is_two_word(input logic [3:0] opc,
                                       input logic [3:0] sub);
    return (opc == OPC_MOV) && (sub == MOV_IMM);
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch sequencer sitting upstream of the CPU's PC and IR_HI/IR_LO register
//   instances. It steps the PC, reads instruction words from a synchronous
//   memory, loads them into the IR halves and offers the completed
//   instruction to the decode/execute FSM over a valid/ready handshake.
//   A retiring instruction may redirect the PC or halt fetching.
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   i_start          one-cycle pulse, begins fetching at the current PC
//   i_pc_q           PC register output
//   o_pc_ld/o_pc_inc PC register load / increment controls
//   o_pc_d           PC register load value (redirect target)
//   o_mem_addr       memory read address
//   i_mem_rdata      memory read data, valid the cycle after o_mem_addr
//   o_ir_d           IR_HI/IR_LO register input
//   o_ir_hi_ld/lo_ld IR half load controls
//   o_ins_valid      IR holds a complete instruction
//   i_ins_ready      consumer retires the instruction this cycle
//   i_redirect       with retire: next PC is i_redirect_addr
//   i_redirect_addr  jump target
//   i_halt           with retire: stop fetching (beats i_redirect)
//
// The PC register's clear input is deliberately not driven from here; the
// PC only moves through ld (redirect) and inc (sequential fetch).
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_pc_q,
  output logic                  o_pc_ld,
  output logic                  o_pc_inc,
  output logic [ADDR_WIDTH-1:0] o_pc_d,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [DATA_WIDTH-1:0] o_ir_d,
  output logic                  o_ir_hi_ld,
  output logic                  o_ir_lo_ld,
  output logic                  o_ins_valid,
  input  logic                  i_ins_ready,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_addr,
  input  logic                  i_halt
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic         w_two_word;

  // Opcode is the top nibble, MOV sub-form the bottom nibble of word one.
  assign w_two_word = is_two_word(i_mem_rdata[DATA_WIDTH-1 -: 4],
                                  i_mem_rdata[3:0]);

  // Reset drops straight to IDLE; since every output is a decode of the
  // state, a fetch in flight is abandoned before any IR load can commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_pc_ld      = 1'b0;
    o_pc_inc     = 1'b0;
    o_pc_d       = '0;
    o_mem_addr   = '0;
    o_ir_d       = '0;
    o_ir_hi_ld   = 1'b0;
    o_ir_lo_ld   = 1'b0;
    o_ins_valid  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_next = ST_FETCH1;
        end
      end

      // Issue the read and bump the PC in the same cycle; the memory
      // returns the word while the PC already points past it.
      ST_FETCH1: begin
        o_mem_addr   = i_pc_q;
        o_pc_inc     = 1'b1;
        w_state_next = ST_LOAD1;
      end

      ST_LOAD1: begin
        o_ir_d       = i_mem_rdata;
        o_ir_hi_ld   = 1'b1;
        w_state_next = w_two_word ? ST_FETCH2 : ST_VALID;
      end

      // PC was incremented in FETCH1 (wrapping naturally at the top of the
      // address space), so the immediate word is read from i_pc_q directly.
      ST_FETCH2: begin
        o_mem_addr   = i_pc_q;
        o_pc_inc     = 1'b1;
        w_state_next = ST_LOAD2;
      end

      ST_LOAD2: begin
        o_ir_d       = i_mem_rdata;
        o_ir_lo_ld   = 1'b1;
        w_state_next = ST_VALID;
      end

      // Only state where the handshake inputs matter. Nothing is loaded or
      // incremented while stalled, so PC and IR stay put.
      ST_VALID: begin
        o_ins_valid = 1'b1;
        if (i_ins_ready) begin
          if (i_halt) begin
            w_state_next = ST_HALT;
          end else begin
            if (i_redirect) begin
              o_pc_ld = 1'b1;
              o_pc_d  = i_redirect_addr;
            end
            w_state_next = ST_FETCH1;
          end
        end
      end

      // Terminal until reset.
      ST_HALT: begin
        w_state_next = ST_HALT;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule
